axis_vc_packet_checker: RTL and testbench
=========================================

# axis_vc_packet_checker

Self-checking AXI-Stream sink for the switch testbench. It sits directly downstream of the switch output port and consumes the packets that the traffic generator injected. It keeps a per-VC FIFO of expected flits, written flit by flit by the generator side. Every received beat is compared against the head of the matching VC queue, and packet, error, length and sticky status counters are exposed to the bench.

## Interface
Parameters:
- C_S_AXIS_TDATA_WIDTH, 128, flit width; must match the AXIS interface TDATA width.
- prio_num, 2, number of priorities.
- vc_num, 2, VCs per priority; total queues Q = prio_num*vc_num.
- FLITS_PER_PKT, 18, required packet length in beats.
- EXP_DEPTH, 54, expected-queue depth per VC in flits (3 packets).

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- S_AXIS_ACLK, in, 1, sole clock.
- S_AXIS_ARESET, in, 1, synchronous active-high reset.
- S_AXIS, AXIS.slave, –, received stream; uses TVALID, TREADY, TDATA and TLAST.
- i_rx_vc, in, $clog2(Q), VC tag of the received stream; sampled only on the first beat of a packet.
- i_exp_valid, in, 1, push one expected flit.
- i_exp_vc, in, $clog2(Q), destination queue for the pushed flit.
- i_exp_data, in, C_S_AXIS_TDATA_WIDTH, expected flit value.
- o_pkt_count, out, 32, packets completed, good or bad.
- o_err_count, out, 32, total data-mismatch, length and underflow errors.
- o_err, out, 1, one-cycle pulse per error.
- o_err_vc, out, $clog2(Q), VC of the most recent error.
- o_exp_overflow, out, 1, sticky flag: a push arrived when the target queue was full.
- o_underflow, out, 1, sticky flag: a beat arrived when the expected queue was empty.
- o_busy, out, 1, high while a packet is in progress.

## Operation
- **Expected queues:** Q circular buffers, each EXP_DEPTH deep, with per-queue read pointer, write pointer and occupancy count.
  - Pointers wrap from EXP_DEPTH-1 to 0.
- **Beat acceptance:** a beat is accepted when TVALID && TREADY in the same cycle.
- **FSM states:** IDLE, RECV, DRAIN.
  - IDLE, on accept: latch i_rx_vc into cur_vc, set beat_idx=1, compare the beat, go to RECV. If TLAST is set on this beat, count a length error and stay in IDLE.
  - RECV, on accept: compare the beat and increment beat_idx.
    - On TLAST: if beat_idx != FLITS_PER_PKT-1, count a length error. Increment o_pkt_count. Return to IDLE.
    - If beat_idx reaches FLITS_PER_PKT-1 without TLAST: count a length error and go to DRAIN.
  - DRAIN: accept beats and pop the queue without comparing. On TLAST, increment o_pkt_count and go to IDLE.
- **Compare rule:** pop the head of queue cur_vc. If the queue is empty, set o_underflow, count an error and do not pop. Otherwise, if TDATA != head, count an error.
- **One error per beat:** a single beat increments o_err_count by at most 1, even if it has several error causes.
- **Simultaneous push and pop on the same queue:** both take effect and the occupancy is unchanged.
- **Push to a full queue:** the flit is dropped, o_exp_overflow is set, and the pointers are unchanged.
- **Counter widths:** all counters are 32 bits and wrap at 2^32-1 to 0.
- **Reset:** on S_AXIS_ARESET, regardless of any packet in progress:
  - FSM returns to IDLE.
  - All queue pointers and occupancy counts go to 0.
  - All counters and sticky flags clear.
  - An interrupted packet is neither counted nor compared.

## Timing
- Reset values of all outputs are 0, including TREADY.
- TREADY first rises in the first cycle after S_AXIS_ARESET is deasserted.
- **Expected-flit availability:** a flit pushed in cycle N can be compared by a beat accepted in cycle N+1. It is not visible to a beat accepted in cycle N.
- **Error outputs:** o_err, o_err_vc and o_err_count are registered and update in the cycle after the offending beat. o_err is high for exactly 1 cycle per error.
- **Packet count:** o_pkt_count updates in the cycle after the TLAST beat.
- **Busy:** o_busy is high from the cycle after the first beat until the cycle after the TLAST beat.
- **Throughput:** 1 beat per cycle, with no bubble between packets.
- **TVALID:** TVALID low never changes state.

## Configuration
- **CHECKER_BACKPRESSURE_EN defined:** TREADY is driven low on cycles where bits [1:0] of a 16-bit LFSR are 2'b00 (about 25% stall).
  - LFSR polynomial: x^16+x^14+x^13+x^11+1.
  - Seed on reset: 16'hACE1.
  - The LFSR advances every cycle.
- **CHECKER_BACKPRESSURE_EN undefined:** TREADY is constant 1 outside reset. The LFSR is not instantiated.

## Test plan
- **Clean packet:** push 18 flits 0x1..0x12 to VC 2, then send the same 18 beats with i_rx_vc=2 and TLAST on beat 18 -> o_pkt_count=1, o_err_count=0, queue 2 empty.
- **Single corrupted beat:** as the clean packet, but beat 5 carries 0xDEAD -> exactly one o_err pulse, with o_err_vc=2. o_err_count=1 and o_pkt_count=1.
- **Short packet:** send 10 beats with TLAST on beat 10 -> one length error, o_pkt_count=1. The next correct packet passes with no new error.
- **Long packet:** send 20 beats with TLAST on beat 20 -> length error at beat 18, then DRAIN until TLAST. o_pkt_count=1 and o_err_count=1.
- **Overflow and underflow:**
  - Push 55 flits to VC 0 -> o_exp_overflow=1 and occupancy stays 54.
  - Send 1 beat on empty VC 3 -> o_underflow=1 and o_err_count increments.
- **Reset mid-packet:** assert reset after beat 7 of a packet -> all counters 0 and TREADY=0 during reset. A fresh 18-flit packet after reset passes clean, including with CHECKER_BACKPRESSURE_EN defined.

Source files
------------

// File: rtl/axis_vc_packet_checker_if.sv
// AXI-Stream bundle (TVALID/TREADY/TDATA/TLAST) for axis_vc_packet_checker.
// The master modport is the packet source; the slave modport is the checker.
interface axis_vc_packet_checker_if #(
   parameter int TDATA_WIDTH = 128
) ();
   logic                   tvalid;
   logic                   tready;
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_vc_packet_checker.sv
// Self-checking AXIS sink: per-VC expected-flit FIFOs compared beat by beat, with status counters.
// Optional macro CHECKER_BACKPRESSURE_EN: LFSR-driven TREADY stalls (~25%).
module axis_vc_packet_checker #(
   parameter int  C_S_AXIS_TDATA_WIDTH = 128,
   parameter int  prio_num             = 2,
   parameter int  vc_num               = 2,
   parameter int  FLITS_PER_PKT        = 18,
   parameter int  EXP_DEPTH            = 54,
   localparam int Q                    = prio_num * vc_num,
   localparam int QW                   = (Q > 1) ? $clog2(Q) : 1
) (
   input  logic                            S_AXIS_ACLK,
   input  logic                            S_AXIS_ARESET,
   axis_vc_packet_checker_if.slave         S_AXIS,
   input  logic [QW-1:0]                   i_rx_vc,
   input  logic                            i_exp_valid,
   input  logic [QW-1:0]                   i_exp_vc,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] i_exp_data,
   output logic [31:0]                     o_pkt_count,
   output logic [31:0]                     o_err_count,
   output logic                            o_err,
   output logic [QW-1:0]                   o_err_vc,
   output logic                            o_exp_overflow,
   output logic                            o_underflow,
   output logic                            o_busy
);
   localparam int PW = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
   localparam int CW = $clog2(EXP_DEPTH + 1);
   localparam int AW = (Q * EXP_DEPTH > 1) ? $clog2(Q * EXP_DEPTH) : 1;
   localparam int BW = $clog2(FLITS_PER_PKT + 1);

   typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

   state_t                          state_q, state_d;
   logic [QW-1:0]                   cur_vc_q, cur_vc_d;
   logic [BW-1:0]                   beat_idx_q, beat_idx_d;
   logic                            len_err, pkt_done;

   logic [C_S_AXIS_TDATA_WIDTH-1:0] mem_q [Q*EXP_DEPTH];
   logic [PW-1:0]                   rd_ptr_q [Q];
   logic [PW-1:0]                   wr_ptr_q [Q];
   logic [CW-1:0]                   count_q  [Q];
   logic [Q-1:0]                    push_v, pop_v;

   logic [31:0]                     pkt_count_q, err_count_q;
   logic                            err_q, overflow_q, underflow_q, run_q;
   logic [QW-1:0]                   err_vc_q;

   logic                            accept, q_empty, compare_en, pop_en;
   logic                            data_mis, under, beat_err, push_full;
   logic [QW-1:0]                   beat_vc;
   logic [AW-1:0]                   head_addr, wr_addr;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] head_data;

   assign accept  = S_AXIS.tvalid && S_AXIS.tready;
   // The first beat of a packet is checked against the VC it announces, before cur_vc is latched.
   assign beat_vc = (state_q == IDLE) ? i_rx_vc : cur_vc_q;

   assign head_addr  = AW'(beat_vc) * AW'(EXP_DEPTH) + AW'(rd_ptr_q[beat_vc]);
   assign wr_addr    = AW'(i_exp_vc) * AW'(EXP_DEPTH) + AW'(wr_ptr_q[i_exp_vc]);
   assign head_data  = mem_q[head_addr];
   assign q_empty    = (count_q[beat_vc] == '0);
   assign compare_en = accept && (state_q != DRAIN);
   assign pop_en     = accept && !q_empty;
   assign data_mis   = compare_en && !q_empty && (S_AXIS.tdata != head_data);
   assign under      = compare_en && q_empty;
   assign beat_err   = data_mis || under || len_err;
   assign push_full  = i_exp_valid && (count_q[i_exp_vc] == CW'(EXP_DEPTH));

   // Asynchronous head read: a flit written at the end of cycle N is visible to a beat in N+1.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (|push_v) begin
         mem_q[wr_addr] <= i_exp_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < Q; gi++) begin : g_queue
         assign push_v[gi] = i_exp_valid && (i_exp_vc == QW'(gi)) &&
                             (count_q[gi] != CW'(EXP_DEPTH));
         assign pop_v[gi]  = pop_en && (beat_vc == QW'(gi));

         always_ff @(posedge S_AXIS_ACLK) begin
            if (S_AXIS_ARESET) begin
               rd_ptr_q[gi] <= '0;
               wr_ptr_q[gi] <= '0;
               count_q[gi]  <= '0;
            end else begin
               if (push_v[gi]) begin
                  wr_ptr_q[gi] <= (wr_ptr_q[gi] == PW'(EXP_DEPTH - 1)) ? '0 : wr_ptr_q[gi] + 1'b1;
               end
               if (pop_v[gi]) begin
                  rd_ptr_q[gi] <= (rd_ptr_q[gi] == PW'(EXP_DEPTH - 1)) ? '0 : rd_ptr_q[gi] + 1'b1;
               end
               case ({push_v[gi], pop_v[gi]})
                  2'b10:   count_q[gi] <= count_q[gi] + 1'b1;
                  2'b01:   count_q[gi] <= count_q[gi] - 1'b1;
                  default: count_q[gi] <= count_q[gi];
               endcase
            end
         end
      end
   endgenerate

   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         state_q    <= IDLE;
         cur_vc_q   <= '0;
         beat_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_vc_q   <= cur_vc_d;
         beat_idx_q <= beat_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cur_vc_d   = cur_vc_q;
      beat_idx_d = beat_idx_q;
      len_err    = 1'b0;
      pkt_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cur_vc_d   = i_rx_vc;
               beat_idx_d = BW'(1);
               if (S_AXIS.tlast) begin
                  len_err  = 1'b1;
                  pkt_done = 1'b1;
               end else begin
                  state_d = RECV;
               end
            end
         end
         RECV: begin
            if (accept) begin
               beat_idx_d = beat_idx_q + 1'b1;
               if (S_AXIS.tlast) begin
                  len_err  = (beat_idx_q != BW'(FLITS_PER_PKT - 1));
                  pkt_done = 1'b1;
                  state_d  = IDLE;
               end else if (beat_idx_q == BW'(FLITS_PER_PKT - 1)) begin
                  len_err = 1'b1;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (accept && S_AXIS.tlast) begin
               pkt_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Several causes on one beat still collapse to a single error event.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         pkt_count_q <= '0;
         err_count_q <= '0;
         err_q       <= 1'b0;
         err_vc_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         run_q <= 1'b1;
         err_q <= beat_err;
         if (beat_err) begin
            err_count_q <= err_count_q + 32'd1;
            err_vc_q    <= beat_vc;
         end
         if (pkt_done) begin
            pkt_count_q <= pkt_count_q + 32'd1;
         end
         if (under) begin
            underflow_q <= 1'b1;
         end
         if (push_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

`ifdef CHECKER_BACKPRESSURE_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps for x^16+x^14+x^13+x^11+1.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign S_AXIS.tready = run_q && (lfsr_q[1:0] != 2'b00);
`else
   assign S_AXIS.tready = run_q;
`endif

   assign o_pkt_count    = pkt_count_q;
   assign o_err_count    = err_count_q;
   assign o_err          = err_q;
   assign o_err_vc       = err_vc_q;
   assign o_exp_overflow = overflow_q;
   assign o_underflow    = underflow_q;
   assign o_busy         = (state_q != IDLE);
endmodule

// File: tb/tb_axis_vc_packet_checker.sv
// Randomized self-checking bench for axis_vc_packet_checker against a queue-level reference model.
module tb_axis_vc_packet_checker;
   localparam int W     = 128;
   localparam int Q     = 4;
   localparam int FLITS = 18;
   localparam int DEPTH = 54;
   localparam int TMO   = 200;

   logic          clk = 1'b0;
   logic          srst;
   logic [1:0]    rx_vc, exp_vc;
   logic          exp_valid;
   logic [W-1:0]  exp_data;
   logic [31:0]   o_pkt_count, o_err_count;
   logic          o_err, o_exp_overflow, o_underflow, o_busy;
   logic [1:0]    o_err_vc;

   always #5 clk = ~clk;

   axis_vc_packet_checker_if #(.TDATA_WIDTH(W)) s_axis ();

   axis_vc_packet_checker dut (
      .S_AXIS_ACLK    (clk),
      .S_AXIS_ARESET  (srst),
      .S_AXIS         (s_axis),
      .i_rx_vc        (rx_vc),
      .i_exp_valid    (exp_valid),
      .i_exp_vc       (exp_vc),
      .i_exp_data     (exp_data),
      .o_pkt_count    (o_pkt_count),
      .o_err_count    (o_err_count),
      .o_err          (o_err),
      .o_err_vc       (o_err_vc),
      .o_exp_overflow (o_exp_overflow),
      .o_underflow    (o_underflow),
      .o_busy         (o_busy)
   );

   // Reference model: expected flits per VC, plus packet-level status.
   logic [W-1:0] mq [Q][$];
   int           m_pkt, m_err, m_nbeat;
   logic [1:0]   m_vc, m_err_vc;
   bit           m_ovf, m_unf;
   int           pulse_cnt;
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] pkt_data [64];

   always @(negedge clk) if (o_err === 1'b1) pulse_cnt++;

   function automatic logic [W-1:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      for (int q = 0; q < Q; q++) mq[q].delete();
      m_pkt = 0; m_err = 0; m_nbeat = 0; m_vc = 0; m_err_vc = 0;
      m_ovf = 0; m_unf = 0; pulse_cnt = 0;
   endtask

   task automatic model_push(input logic [1:0] vc, input logic [W-1:0] d);
      if (mq[vc].size() >= DEPTH) m_ovf = 1;
      else mq[vc].push_back(d);
   endtask

   // Beat n of a packet: beats 1..FLITS are compared, later ones only consume flits.
   task automatic model_beat(input logic [1:0] vc, input logic [W-1:0] d, input bit last);
      bit           e = 0;
      logic [W-1:0] h;
      m_nbeat++;
      if (m_nbeat == 1) m_vc = vc;
      if (m_nbeat <= FLITS) begin
         if (mq[m_vc].size() == 0) begin
            m_unf = 1; e = 1;
         end else begin
            h = mq[m_vc].pop_front();
            if (h != d) e = 1;
         end
         if (last && m_nbeat != FLITS) e = 1;
         if (!last && m_nbeat == FLITS) e = 1;
      end else if (mq[m_vc].size() != 0) begin
         h = mq[m_vc].pop_front();
      end
      if (e) begin m_err++; m_err_vc = m_vc; end
      if (last) begin m_pkt++; m_nbeat = 0; end
   endtask

   task automatic prep(input logic [1:0] vc, input int n, input bit seq);
      for (int i = 0; i < n; i++) begin
         pkt_data[i] = seq ? W'(i + 1) : rand128();
         @(negedge clk);
         exp_valid = 1'b1; exp_vc = vc; exp_data = pkt_data[i];
         model_push(vc, pkt_data[i]);
      end
      @(negedge clk);
      exp_valid = 1'b0;
   endtask

   // Returns at the negedge before the accepting posedge.
   task automatic send_beat(input logic [1:0] vc, input logic [W-1:0] d, input bit last);
      int t = 0;
      @(negedge clk);
      s_axis.tvalid = 1'b1; s_axis.tdata = d; s_axis.tlast = last; rx_vc = vc;
      while (s_axis.tready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin
         checks++; errors++;
         $display("FAIL tready_wait: got tready=%b required 1 within %0d cycles", s_axis.tready, TMO);
      end else begin
         model_beat(vc, d, last);
      end
   endtask

   task automatic end_tx();
      @(negedge clk);
      s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [1:0] vc, input int n, input int bad_idx, input logic [W-1:0] bad_val);
      for (int i = 0; i < n; i++)
         send_beat(vc, (i == bad_idx) ? bad_val : pkt_data[i], i == n - 1);
      end_tx();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b required 0", s_axis.tready); end
      checks++; if (o_pkt_count !== 32'd0 || o_err_count !== 32'd0) begin errors++; $display("FAIL reset_counts: got pkt=%0d err=%0d required 0 0", o_pkt_count, o_err_count); end
      checks++; if ({o_err, o_exp_overflow, o_underflow, o_busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b required 0000", {o_err, o_exp_overflow, o_underflow, o_busy}); end
      srst = 1'b0;
      model_reset();
      @(negedge clk);
      checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL reset_tready_rise: got %b required 1", s_axis.tready); end
   endtask

   task automatic test_clean();
      prep(2'd2, FLITS, 1'b1);
      for (int i = 0; i < FLITS; i++) begin
         send_beat(2'd2, pkt_data[i], i == FLITS - 1);
         if (i == 1) begin
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL clean_busy_mid: got %b required 1", o_busy); end
         end
      end
      @(negedge clk);
      s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clean_busy_end: got %b required 0", o_busy); end
      repeat (2) @(negedge clk);
      checks++; if (o_pkt_count !== 32'(m_pkt)) begin errors++; $display("FAIL clean_pkt: got %0d required %0d", o_pkt_count, m_pkt); end
      checks++; if (o_err_count !== 32'(m_err)) begin errors++; $display("FAIL clean_err: got %0d required %0d", o_err_count, m_err); end
      checks++; if (int'(dut.count_q[2]) !== mq[2].size()) begin errors++; $display("FAIL clean_occ: got %0d required %0d", dut.count_q[2], mq[2].size()); end
   endtask

   task automatic test_corrupt();
      int p0 = pulse_cnt;
      prep(2'd2, FLITS, 1'b1);
      send_pkt(2'd2, FLITS, 4, W'(16'hDEAD));
      checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL corrupt_pulses: got %0d required 1", pulse_cnt - p0); end
      checks++; if (o_err_vc !== m_err_vc) begin errors++; $display("FAIL corrupt_err_vc: got %0d required %0d", o_err_vc, m_err_vc); end
      checks++; if (o_err_count !== 32'(m_err)) begin errors++; $display("FAIL corrupt_err: got %0d required %0d", o_err_count, m_err); end
      checks++; if (o_pkt_count !== 32'(m_pkt)) begin errors++; $display("FAIL corrupt_pkt: got %0d required %0d", o_pkt_count, m_pkt); end
   endtask

   task automatic test_short();
      prep(2'd1, 10, 1'b0);
      send_pkt(2'd1, 10, -1, '0);
      checks++; if (o_err_count !== 32'(m_err)) begin errors++; $display("FAIL short_err: got %0d required %0d", o_err_count, m_err); end
      prep(2'd1, FLITS, 1'b0);
      send_pkt(2'd1, FLITS, -1, '0);
      checks++; if (o_err_count !== 32'(m_err) || o_pkt_count !== 32'(m_pkt)) begin errors++; $display("FAIL short_next: got err=%0d pkt=%0d required %0d %0d", o_err_count, o_pkt_count, m_err, m_pkt); end
   endtask

   task automatic test_long();
      prep(2'd3, 20, 1'b0);
      send_pkt(2'd3, 20, -1, '0);
      checks++; if (o_err_count !== 32'(m_err) || o_pkt_count !== 32'(m_pkt)) begin errors++; $display("FAIL long_counts: got err=%0d pkt=%0d required %0d %0d", o_err_count, o_pkt_count, m_err, m_pkt); end
      checks++; if (int'(dut.count_q[3]) !== mq[3].size()) begin errors++; $display("FAIL long_occ: got %0d required %0d", dut.count_q[3], mq[3].size()); end
   endtask

   task automatic test_underflow();
      int p0 = pulse_cnt;
      send_beat(2'd3, rand128(), 1'b1);
      end_tx();
      checks++; if (o_underflow !== m_unf) begin errors++; $display("FAIL underflow_flag: got %b required %b", o_underflow, m_unf); end
      checks++; if (o_err_count !== 32'(m_err) || pulse_cnt - p0 !== 1) begin errors++; $display("FAIL underflow_err: got err=%0d pulses=%0d required %0d 1", o_err_count, pulse_cnt - p0, m_err); end
   endtask

   // Push and beat in the same cycle: the flit must not be seen until the next beat.
   task automatic test_same_cycle();
      int           t = 0;
      logic [W-1:0] d = rand128();
      @(negedge clk);
      while (s_axis.tready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      s_axis.tvalid = 1'b1; s_axis.tdata = d; s_axis.tlast = 1'b1; rx_vc = 2'd1;
      exp_valid = 1'b1; exp_vc = 2'd1; exp_data = d;
      model_beat(2'd1, d, 1'b1);
      model_push(2'd1, d);
      @(negedge clk);
      s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; exp_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (int'(dut.count_q[1]) !== mq[1].size()) begin errors++; $display("FAIL same_occ: got %0d required %0d", dut.count_q[1], mq[1].size()); end
      checks++; if (o_err_count !== 32'(m_err)) begin errors++; $display("FAIL same_err: got %0d required %0d", o_err_count, m_err); end
      prep(2'd1, FLITS - 1, 1'b0);
      for (int i = FLITS - 1; i > 0; i--) pkt_data[i] = pkt_data[i-1];
      pkt_data[0] = d;
      send_pkt(2'd1, FLITS, -1, '0);
      checks++; if (o_err_count !== 32'(m_err) || o_pkt_count !== 32'(m_pkt)) begin errors++; $display("FAIL same_next: got err=%0d pkt=%0d required %0d %0d", o_err_count, o_pkt_count, m_err, m_pkt); end
   endtask

   task automatic test_random();
      for (int p = 0; p < 8; p++) begin
         logic [1:0] vc  = 2'($urandom_range(0, 3));
         int         sel = $urandom_range(0, 3);
         int         len = (sel == 0) ? 10 : (sel == 1) ? 20 : FLITS;
         int         bad = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
         prep(vc, len, 1'b0);
         send_pkt(vc, len, bad, ~pkt_data[(bad < 0) ? 0 : bad]);
         checks++; if (o_err_count !== 32'(m_err) || o_pkt_count !== 32'(m_pkt)) begin errors++; $display("FAIL random_%0d: got err=%0d pkt=%0d required %0d %0d", p, o_err_count, o_pkt_count, m_err, m_pkt); end
         checks++; if (int'(dut.count_q[vc]) !== mq[vc].size() || o_err_vc !== m_err_vc) begin errors++; $display("FAIL random_occ_%0d: got occ=%0d vc=%0d required %0d %0d", p, dut.count_q[vc], o_err_vc, mq[vc].size(), m_err_vc); end
      end
   endtask

   task automatic test_overflow();
      prep(2'd0, DEPTH + 1, 1'b0);
      repeat (2) @(negedge clk);
      checks++; if (o_exp_overflow !== m_ovf) begin errors++; $display("FAIL overflow_flag: got %b required %b", o_exp_overflow, m_ovf); end
      checks++; if (int'(dut.count_q[0]) !== mq[0].size()) begin errors++; $display("FAIL overflow_occ: got %0d required %0d", dut.count_q[0], mq[0].size()); end
   endtask

   task automatic test_reset_mid();
      int t = 0;
      prep(2'd2, FLITS, 1'b0);
      for (int i = 0; i < 7; i++) send_beat(2'd2, pkt_data[i], 1'b0);
      @(negedge clk);
      s_axis.tvalid = 1'b0; srst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (o_pkt_count !== 32'd0 || o_err_count !== 32'd0 || s_axis.tready !== 1'b0) begin errors++; $display("FAIL rstmid_state: got pkt=%0d err=%0d tready=%b required 0 0 0", o_pkt_count, o_err_count, s_axis.tready); end
      checks++; if ({o_exp_overflow, o_underflow, o_busy} !== 3'b0 || dut.count_q[0] !== '0 || dut.count_q[2] !== '0) begin errors++; $display("FAIL rstmid_flags: got %b occ0=%0d occ2=%0d required 000 0 0", {o_exp_overflow, o_underflow, o_busy}, dut.count_q[0], dut.count_q[2]); end
      srst = 1'b0;
      model_reset();
      while (s_axis.tready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      prep(2'd2, FLITS, 1'b0);
      send_pkt(2'd2, FLITS, -1, '0);
      checks++; if (o_err_count !== 32'(m_err) || o_pkt_count !== 32'(m_pkt)) begin errors++; $display("FAIL rstmid_fresh: got err=%0d pkt=%0d required %0d %0d", o_err_count, o_pkt_count, m_err, m_pkt); end
   endtask

   initial begin
      srst = 1'b1; exp_valid = 1'b0; exp_vc = '0; exp_data = '0; rx_vc = '0;
      s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
      model_reset();
      test_reset();
      test_clean();
      test_corrupt();
      test_short();
      test_long();
      test_underflow();
      test_same_cycle();
      test_random();
      test_overflow();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
